// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from PC into a DEPTH-entry
// circular buffer of {pc, instr} and presents the head first-word-fall-through.
// Ports: CLK/nRST; cache side ihit/imemload/imemREN/imemaddr; control
//   redirect/redirect_addr/halt_in; consumer deq/valid/instr/instr_pc/npc;
//   status count/halted.
// Latency: a push on edge N is visible at the head on cycle N+1 if the queue was empty.
// Backpressure: no fetch request while the queue is full, halted or redirecting.
module fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          DEPTH   = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     ihit,
  input  logic [31:0]              imemload,
  output logic                     imemREN,
  output logic [31:0]              imemaddr,
  input  logic                     redirect,
  input  logic [31:0]              redirect_addr,
  input  logic                     halt_in,
  input  logic                     deq,
  output logic                     valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              npc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     mem_q [DEPTH];

  logic push, pop;
  logic unused_addr_bits;

  // Word alignment drops the low address bits.
  assign unused_addr_bits = ^redirect_addr[1:0];

  // Request depends only on state, occupancy and redirect; deq never feeds it.
  assign imemREN = (state_q == RUN) && (count_q < FULL) && !redirect;
  assign push    = imemREN && ihit;
  assign pop     = deq && valid && !redirect;

  assign imemaddr = pc_q;
  assign valid    = (count_q != '0);
  assign count    = count_q;
  assign halted   = (state_q == HALT);
  assign instr    = valid ? mem_q[head_q][31:0]  : 32'h0;
  assign instr_pc = valid ? mem_q[head_q][63:32] : 32'h0;
  assign npc      = instr_pc + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      // Flush: drop everything, including this cycle's hit/deq/halt_in.
      count_d = '0;
      head_d  = tail_q;
      pc_d    = {redirect_addr[31:2], 2'b00};
    end else begin
      if (push) begin
        tail_d = tail_q + AW'(1);
        pc_d   = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // The push in the same cycle still lands; requests stop from next cycle.
      if (state_q == RUN && halt_in) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; outputs are masked while the queue is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[tail_q] <= {pc_q, imemload};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        halt_in = 1'b0;
  logic        deq = 1'b0;
  logic        valid;
  logic [31:0] instr, instr_pc, npc;
  logic [2:0]  count;
  logic        halted;

  fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
    .redirect_addr(redirect_addr), .halt_in(halt_in), .deq(deq),
    .valid(valid), .instr(instr), .instr_pc(instr_pc), .npc(npc),
    .count(count), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] npc;
    logic [2:0]  cnt;
    logic        hlt;
  } exp_t;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of fetched {pc, word} pairs.
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic        mhalt;
  exp_t        exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ren  = !mhalt && (mq.size() < DEPTH) && !redirect;
    e.addr = mpc;
    e.vld  = (mq.size() != 0);
    e.ins  = e.vld ? mq[0][31:0]  : 32'h0;
    e.ipc  = e.vld ? mq[0][63:32] : 32'h0;
    e.npc  = e.ipc + 32'd4;
    e.cnt  = 3'(mq.size());
    e.hlt  = mhalt;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = PC_INIT;
    mhalt = 1'b0;
  endtask

  // Drive one cycle's inputs at the falling edge, record the expected
  // outputs for this cycle, then advance the model past the next rising edge.
  task automatic cycle(input logic h, input logic [31:0] ld, input logic r,
                       input logic [31:0] ra, input logic hl, input logic d);
    bit can_fetch, did_pop;
    @(negedge CLK);
    nRST = 1'b1;
    ihit = h; imemload = ld; redirect = r; redirect_addr = ra; halt_in = hl; deq = d;
    #1;
    push_exp();
    if (r) begin
      mq.delete();
      mpc = {ra[31:2], 2'b00};
    end else begin
      can_fetch = !mhalt && (mq.size() < DEPTH);
      did_pop   = d && (mq.size() != 0);
      if (did_pop) void'(mq.pop_front());
      if (can_fetch && h) begin
        mq.push_back({mpc, ld});
        mpc = mpc + 32'd4;
      end
      if (hl) mhalt = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    ihit = 0; redirect = 0; halt_in = 0; deq = 0;
    #1;
    model_reset();
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // Monitor: compares every presented output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imemREN",  {31'h0, imemREN}, {31'h0, e.ren});
        chk("imemaddr", imemaddr, e.addr);
        chk("valid",    {31'h0, valid},   {31'h0, e.vld});
        chk("instr",    instr, e.ins);
        chk("instr_pc", instr_pc, e.ipc);
        chk("npc",      npc, e.npc);
        chk("count",    {29'h0, count},   {29'h0, e.cnt});
        chk("halted",   {31'h0, halted},  {31'h0, e.hlt});
      end
    end
  end

  initial begin
    logic [31:0] prev_pc;
    model_reset();
    do_reset();
    // Asynchronous reset state, checked before any rising edge in reset.
    chk("rst_ren",   {31'h0, imemREN}, 32'h1);
    chk("rst_addr",  imemaddr, PC_INIT);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);

    // Fill: PCs 0,4,8,C, then full with PC held at 0x10.
    for (int i = 0; i < 4; i++) cycle(1, 32'hA000_0000 + i, 0, 0, 0, 0);
    cycle(1, 32'hDEAD_0000, 0, 0, 0, 0);
    chk("full_cnt",  {29'h0, count}, 32'd4);
    chk("full_ren",  {31'h0, imemREN}, 32'h0);
    chk("full_addr", imemaddr, 32'h10);
    // One pop from full; request stays low in the pop cycle itself.
    cycle(1, 32'hDEAD_0001, 0, 0, 0, 1);
    chk("pop_pc",    instr_pc, 32'h0);
    chk("pop_ren",   {31'h0, imemREN}, 32'h0);
    cycle(1, 32'hA000_0010, 0, 0, 0, 0);
    chk("refill_cnt",  {29'h0, count}, 32'd3);
    chk("refill_ren",  {31'h0, imemREN}, 32'h1);
    chk("refill_addr", imemaddr, 32'h10);
    // Drain to two, then redirect with a coincident hit.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 32'hBAD0_BAD0, 1, 32'h0000_0043, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("redir_cnt",  {29'h0, count}, 32'd0);
    chk("redir_vld",  {31'h0, valid}, 32'h0);
    chk("redir_addr", imemaddr, 32'h40);
    // Streaming: occupancy constant, PC steps by 4, pointers wrap.
    cycle(1, 32'h1111_0000, 0, 0, 0, 0);
    cycle(1, 32'h1111_0001, 0, 0, 0, 0);
    prev_pc = 32'h3C;
    for (int i = 0; i < 9; i++) begin
      cycle(1, 32'h2222_0000 + i, 0, 0, 0, 1);
      chk("stream_cnt", {29'h0, count}, 32'd2);
      chk("stream_pc",  instr_pc, prev_pc + 32'd4);
      prev_pc = instr_pc;
    end

    // Halt while pushing PC 8 with one entry queued.
    do_reset();
    cycle(1, 32'h3333_0000, 0, 0, 0, 0);
    cycle(1, 32'h3333_0004, 0, 0, 0, 1);
    cycle(1, 32'h3333_0008, 0, 0, 1, 0);
    cycle(1, 32'h0, 0, 0, 0, 0);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_ren",  {31'h0, imemREN}, 32'h0);
    chk("halt_cnt",  {29'h0, count}, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain_vld", {31'h0, valid}, 32'h0);
    cycle(0, 0, 1, 32'h100, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("redir_halted", {31'h0, halted}, 32'h1);

    // Reset while halted with three entries.
    do_reset();
    cycle(1, 32'h4444_0000, 0, 0, 0, 0);
    cycle(1, 32'h4444_0004, 0, 0, 0, 0);
    cycle(1, 32'h4444_0008, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", {29'h0, count}, 32'd3);
    do_reset();
    chk("rst2_cnt",  {29'h0, count}, 32'd0);
    chk("rst2_halt", {31'h0, halted}, 32'h0);
    chk("rst2_addr", imemaddr, 32'h0);
    chk("rst2_ren",  {31'h0, imemREN}, 32'h1);

    // Address wrap at the top of memory.
    cycle(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    cycle(1, 32'h5555_5555, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imemaddr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom,
              $urandom_range(0, 19) == 0, $urandom,
              $urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0);
      end
    end
    idle(3);
    @(negedge CLK);
    #3;
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
